// File: rtl/rpn_stack_pop_pkg.sv
// Shared definitions for the RPN operand-stack pop controller:
// default widths, FSM state encoding and the operand-count helper.
package rpn_stack_pop_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_RD_A = 3'b001,
    S_WT_A = 3'b010,
    S_RD_B = 3'b011,
    S_WT_B = 3'b100,
    S_DONE = 3'b101
  } state_e;

  // Number of stack entries a pop consumes: two for a binary op, one otherwise.
  function automatic logic [1:0] pop_need(input logic two);
    logic [1:0] need;
    if (two) begin
      need = 2'd2;
    end else begin
      need = 2'd1;
    end
    return need;
  endfunction

endpackage

// File: rtl/rpn_stack_pop_if.sv
// Bundle of the pop controller's request, stack-RAM and ALU-side signals.
// master = the caller/environment, slave = the pop controller.
interface rpn_stack_pop_if
  import rpn_stack_pop_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              pop_req;
  logic              pop_two;
  logic [ADDR_W-1:0] sp_in;
  logic [DATA_W-1:0] ram_rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              op_valid;
  logic [ADDR_W-1:0] sp_out;
  logic              sp_load;
  logic              underflow;
  logic              busy;

  modport master (
    output pop_req, pop_two, sp_in, ram_rd_data,
    input  ram_addr, operand_a, operand_b, op_valid, sp_out, sp_load, underflow, busy
  );

  modport slave (
    input  pop_req, pop_two, sp_in, ram_rd_data,
    output ram_addr, operand_a, operand_b, op_valid, sp_out, sp_load, underflow, busy
  );

endinterface

// File: rtl/rpn_stack_pop_reg_load_enable.sv
// Width-parameterised register with load enable and synchronous
// active-low reset to zero. Reset wins over the load enable.
module reg_load_enable #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next value: take the new data when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // Storage flop with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= {W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/rpn_stack_pop.sv
// Read-side controller of the RPN operand stack. Pops one or two entries
// from the synchronous stack RAM (one-cycle read latency), presents them
// to the ALU with a one-cycle op_valid strobe, and asks the stack pointer
// register to load the decremented pointer with sp_load in the same cycle.
module rpn_stack_pop
  import rpn_stack_pop_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic           CLOCK_50,
  input logic           RESET_N,
  rpn_stack_pop_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;            // pointer sampled at request
  logic              two_q, two_d;          // pop_two sampled at request
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              op_valid_q, op_valid_d;
  logic              sp_load_q, sp_load_d;
  logic              underflow_q, underflow_d;
  logic              busy_q, busy_d;

  logic              opa_en_s;
  logic              opb_en_s;
  logic              spo_en_s;
  logic [DATA_W-1:0] opb_data_s;
  logic [ADDR_W-1:0] spo_data_s;
  logic              short_s;               // fewer entries than requested

  assign short_s = (bus.sp_in < ADDR_W'(pop_need(bus.pop_two)));

  // FSM next state, registered strobes and enables for the operand/SP registers.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    two_d       = two_q;
    ram_addr_d  = ram_addr_q;
    op_valid_d  = 1'b0;
    sp_load_d   = 1'b0;
    underflow_d = 1'b0;
    opa_en_s    = 1'b0;
    opb_en_s    = 1'b0;
    spo_en_s    = 1'b0;
    opb_data_s  = {DATA_W{1'b0}};
    spo_data_s  = sp_q - ADDR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.pop_req) begin
          if (short_s) begin
            // Refuse without touching RAM or the stack pointer.
            underflow_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            sp_d       = bus.sp_in;
            two_d      = bus.pop_two;
            ram_addr_d = bus.sp_in - ADDR_W'(1);
            state_d    = S_RD_A;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RD_A: begin
        state_d = S_WT_A;
      end

      S_WT_A: begin
        opa_en_s = 1'b1;
        if (two_q) begin
          ram_addr_d = sp_q - ADDR_W'(2);
          state_d    = S_RD_B;
        end else begin
          opb_en_s   = 1'b1;
          opb_data_s = {DATA_W{1'b0}};
          spo_en_s   = 1'b1;
          spo_data_s = sp_q - ADDR_W'(1);
          op_valid_d = 1'b1;
          sp_load_d  = 1'b1;
          state_d    = S_DONE;
        end
      end

      S_RD_B: begin
        state_d = S_WT_B;
      end

      S_WT_B: begin
        opb_en_s   = 1'b1;
        opb_data_s = bus.ram_rd_data;
        spo_en_s   = 1'b1;
        spo_data_s = sp_q - ADDR_W'(2);
        op_valid_d = 1'b1;
        sp_load_d  = 1'b1;
        state_d    = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered control outputs; reset aborts any pop in flight.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      sp_q        <= {ADDR_W{1'b0}};
      two_q       <= 1'b0;
      ram_addr_q  <= {ADDR_W{1'b0}};
      op_valid_q  <= 1'b0;
      sp_load_q   <= 1'b0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      two_q       <= two_d;
      ram_addr_q  <= ram_addr_d;
      op_valid_q  <= op_valid_d;
      sp_load_q   <= sp_load_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
    end
  end

  reg_load_enable #(.W(DATA_W)) u_operand_a (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .en    (opa_en_s),
    .d     (bus.ram_rd_data),
    .q     (bus.operand_a)
  );

  reg_load_enable #(.W(DATA_W)) u_operand_b (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .en    (opb_en_s),
    .d     (opb_data_s),
    .q     (bus.operand_b)
  );

  reg_load_enable #(.W(ADDR_W)) u_sp_out (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .en    (spo_en_s),
    .d     (spo_data_s),
    .q     (bus.sp_out)
  );

  assign bus.ram_addr  = ram_addr_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.sp_load   = sp_load_q;
  assign bus.underflow = underflow_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rpn_stack_pop.sv
// Self-checking bench for rpn_stack_pop. A behavioural stack RAM with a
// one-cycle registered read sits on the bus; expected results come from
// plain stack rules (top = mem[sp-1], second = mem[sp-2], new sp = sp-need,
// refuse when sp < need, fixed latency/spacing per pop kind).
module tb_rpn_stack_pop;
  import rpn_stack_pop_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;

  rpn_stack_pop_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  rpn_stack_pop #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [DW-1:0] mem [0:255];

  // Synchronous-read stack RAM.
  always @(posedge CLOCK_50) bus.ram_rd_data <= mem[bus.ram_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
    chk({tag, "_opa"},  32'(bus.operand_a), 32'd0);
    chk({tag, "_opb"},  32'(bus.operand_b), 32'd0);
    chk({tag, "_spo"},  32'(bus.sp_out), 32'd0);
    chk({tag, "_vld"},  32'(bus.op_valid), 32'd0);
    chk({tag, "_spl"},  32'(bus.sp_load), 32'd0);
    chk({tag, "_uf"},   32'(bus.underflow), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // One complete pop request checked cycle by cycle against stack rules.
  // noise: scramble the inputs while the controller is busy.
  task automatic run_pop(input logic [7:0] sp, input bit two, input bit noise);
    int            need;
    int            lat;
    logic [DW-1:0] ea, eb;
    logic [AW-1:0] es;
    need = two ? 2 : 1;
    bus.pop_req = 1'b1;
    bus.pop_two = two;
    bus.sp_in   = sp;
    tick();                                   // request sampled here
    if (int'(sp) < need) begin
      bus.pop_req = 1'b0;
      chk("uf_strobe", 32'(bus.underflow), 32'd1);
      chk("uf_busy",   32'(bus.busy), 32'd0);
      chk("uf_valid",  32'(bus.op_valid), 32'd0);
      chk("uf_spload", 32'(bus.sp_load), 32'd0);
      tick();
      chk("uf_clear",  32'(bus.underflow), 32'd0);
      chk("uf_busy2",  32'(bus.busy), 32'd0);
      chk("uf_valid2", 32'(bus.op_valid), 32'd0);
      chk("uf_spl2",   32'(bus.sp_load), 32'd0);
    end else begin
      ea  = mem[8'(sp - 8'd1)];
      eb  = two ? mem[8'(sp - 8'd2)] : 8'h00;
      es  = 8'(int'(sp) - need);
      lat = two ? 4 : 2;                      // edges after the request edge
      chk("busy_start", 32'(bus.busy), 32'd1);
      chk("addr_a",     32'(bus.ram_addr), 32'(8'(sp - 8'd1)));
      chk("no_uf",      32'(bus.underflow), 32'd0);
      for (int c = 1; c <= lat + 1; c++) begin
        if (noise && c <= lat) begin
          bus.pop_req = 1'($urandom);
          bus.pop_two = 1'($urandom);
          bus.sp_in   = 8'($urandom);
        end else begin
          bus.pop_req = 1'b0;
        end
        if (c == 1) bus.pop_req = noise ? bus.pop_req : 1'b0;
        tick();
        if (two && c == 2) chk("addr_b", 32'(bus.ram_addr), 32'(8'(sp - 8'd2)));
        chk("op_valid_t", 32'(bus.op_valid), 32'(c == lat));
        chk("sp_load_t",  32'(bus.sp_load),  32'(c == lat));
        chk("busy_t",     32'(bus.busy),     32'(c <= lat));
        if (c >= lat) begin
          chk("operand_a", 32'(bus.operand_a), 32'(ea));
          chk("operand_b", 32'(bus.operand_b), 32'(eb));
          chk("sp_out",    32'(bus.sp_out),    32'(es));
        end
      end
    end
  endtask

  initial begin
    bit exp_v [0:31];
    int next_free;
    logic [7:0] sp_r;
    bit two_r;

    bus.pop_req = 1'b0;
    bus.pop_two = 1'b0;
    bus.sp_in   = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Reset state
    RESET_N = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    RESET_N = 1'b1;
    tick();

    // Double pop from sp=5
    mem[4] = 8'h11;
    mem[3] = 8'h22;
    run_pop(8'd5, 1'b1, 1'b0);

    // Single pop of the last entry
    mem[0] = 8'h7F;
    run_pop(8'd1, 1'b0, 1'b0);

    // Underflow cases
    run_pop(8'd0, 1'b0, 1'b0);
    run_pop(8'd1, 1'b1, 1'b0);

    // Reset while waiting for operand A
    bus.pop_req = 1'b1; bus.pop_two = 1'b0; bus.sp_in = 8'd5;
    tick();
    bus.pop_req = 1'b0;
    tick();
    RESET_N = 1'b0;
    tick();
    chk_all_zero("midreset");
    tick();
    chk("midreset_spl", 32'(bus.sp_load), 32'd0);
    RESET_N = 1'b1;
    tick();
    chk("post_reset_spl", 32'(bus.sp_load), 32'd0);
    run_pop(8'd5, 1'b0, 1'b0);

    // Level-held pop_req: accepted every 4 cycles
    for (int i = 0; i < 32; i++) exp_v[i] = 1'b0;
    next_free = 0;
    bus.pop_req = 1'b1; bus.pop_two = 1'b0; bus.sp_in = 8'd200;
    for (int t = 0; t < 26; t++) begin
      if (t == 20) bus.pop_req = 1'b0;
      if (t < 20 && t >= next_free) begin
        exp_v[t + 2] = 1'b1;
        next_free    = t + 4;
      end
      tick();
      chk("held_valid", 32'(bus.op_valid), 32'(exp_v[t]));
      chk("held_spl",   32'(bus.sp_load),  32'(exp_v[t]));
      if (exp_v[t]) begin
        chk("held_opa", 32'(bus.operand_a), 32'(mem[199]));
        chk("held_opb", 32'(bus.operand_b), 32'd0);
        chk("held_spo", 32'(bus.sp_out),    32'd199);
      end
    end

    // Full stack double pop
    mem[254] = 8'hAA;
    mem[253] = 8'hBB;
    run_pop(8'd255, 1'b1, 1'b0);

    // Randomised pops with input noise while busy
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3, 0) == 0) sp_r = 8'($urandom_range(3, 0));
      else                           sp_r = 8'($urandom);
      two_r = 1'($urandom);
      run_pop(sp_r, two_r, 1'($urandom));
      repeat ($urandom_range(2, 0)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
